// File: rtl/pixel_stream_loader_pkg.sv
// pixel_stream_loader_pkg
//   Shared definitions for the pixel stream loader:
//   - state_t: FSM encoding (COLLECT/SETUP/STROBE/HOLD, 2 bits)
//   - BYTES_PER_PIXEL, COLOR_W: stream/pixel geometry
//   - pack_grb(): places the R,G,B channels into the driver's {G,R,B} word
package pixel_stream_loader_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  localparam int BYTES_PER_PIXEL = 3;
  localparam int COLOR_W         = 24;

  // GRB packing order: G in [23:16], R in [15:8], B in [7:0].
  function automatic logic [COLOR_W-1:0] pack_grb(input logic [7:0] red,
                                                  input logic [7:0] green,
                                                  input logic [7:0] blue);
    return {green, red, blue};
  endfunction

endpackage

// File: rtl/pixel_stream_loader_if.sv
// pixel_stream_loader_if
//   Bundles the byte-stream input and the driver write port of the loader.
//   Handshake: a byte transfers on a rising clk edge where s_valid and s_ready
//   are both high; s_valid may drop at any time, s_data/s_sof only matter
//   while s_valid is high.
//   Signals: s_data[7:0], s_valid, s_sof, s_ready, pix_color[23:0],
//            pix_address[ADDR_W-1:0], pix_wr, frame_done, busy,
//            brightness[7:0] (only when PIXEL_BRIGHTNESS_EN is defined).
//   Modports: slave = loader side, master = stream source / observer side.
interface pixel_stream_loader_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_sof;
  logic              s_ready;
  logic [23:0]       pix_color;
  logic [ADDR_W-1:0] pix_address;
  logic              pix_wr;
  logic              frame_done;
  logic              busy;
`ifdef PIXEL_BRIGHTNESS_EN
  logic [7:0]        brightness;

  modport slave (
    input  s_data, s_valid, s_sof, brightness,
    output s_ready, pix_color, pix_address, pix_wr, frame_done, busy
  );
  modport master (
    output s_data, s_valid, s_sof, brightness,
    input  s_ready, pix_color, pix_address, pix_wr, frame_done, busy
  );
`else
  modport slave (
    input  s_data, s_valid, s_sof,
    output s_ready, pix_color, pix_address, pix_wr, frame_done, busy
  );
  modport master (
    output s_data, s_valid, s_sof,
    input  s_ready, pix_color, pix_address, pix_wr, frame_done, busy
  );
`endif
endinterface

// File: rtl/pixel_stream_loader_scale.sv
// pixel_scale
//   Per-channel brightness scaling: o_ch = (i_ch * (i_brightness + 1)) >> 8.
//   brightness=255 passes the channel through, brightness=0 gives 0.
//   Purely combinational. Only built when PIXEL_BRIGHTNESS_EN is defined.
//   Ports: i_ch[7:0] channel in, i_brightness[7:0] gain, o_ch[7:0] scaled out.
`ifdef PIXEL_BRIGHTNESS_EN
module pixel_scale (
  input  logic [7:0] i_ch,
  input  logic [7:0] i_brightness,
  output logic [7:0] o_ch
);
  logic [8:0]  w_gain;
  logic [15:0] w_prod;

  // Largest product is 255*256 = 65280, so 16 bits never overflow.
  assign w_gain = {1'b0, i_brightness} + 9'd1;
  assign w_prod = 16'(i_ch) * 16'(w_gain);
  assign o_ch   = w_prod[15:8];
endmodule
`endif

// File: rtl/pixel_stream_loader.sv
// pixel_stream_loader
//   Packs an R,G,B byte stream into 24-bit {G,R,B} words and writes them into
//   the neopixel driver colour buffer with an auto-incrementing LED address.
//   Write sequence per pixel: SETUP (data/address valid) -> STROBE (pix_wr=1)
//   -> HOLD (data held, address counter advanced, frame_done on last LED).
//   Optional feature macro: PIXEL_BRIGHTNESS_EN adds bus.brightness scaling.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     bus          pixel_stream_loader_if.slave (stream in, driver write out)
//     o_dbg_state  current FSM state, for observation only
module pixel_stream_loader
  import pixel_stream_loader_pkg::*;
#(
  parameter int NUM_LEDS = 16,
  parameter int ADDR_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pixel_stream_loader_if.slave  bus,
  output state_t                o_dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LEDS - 1);
  localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_PIXEL - 1);

  state_t              r_state, w_next;
  logic [1:0]          r_byte_cnt;
  logic [7:0]          r_red, r_green;
  logic [ADDR_W-1:0]   r_addr_cnt;
  logic [COLOR_W-1:0]  r_pix_color;
  logic [ADDR_W-1:0]   r_pix_addr;
  logic                r_wr, r_frame_done, r_ready;
  logic                w_accept, w_last_byte;
  logic [7:0]          w_red_s, w_green_s, w_blue_s;

  // r_ready is only ever high while in COLLECT, but the state term keeps
  // the intent explicit.
  assign w_accept    = bus.s_valid & r_ready & (r_state == ST_COLLECT);
  // A start-of-frame byte is always byte 0, so it can never complete a pixel.
  assign w_last_byte = w_accept & ~bus.s_sof & (r_byte_cnt == LAST_BYTE);

`ifdef PIXEL_BRIGHTNESS_EN
  pixel_scale u_scale_r (.i_ch(r_red),      .i_brightness(bus.brightness), .o_ch(w_red_s));
  pixel_scale u_scale_g (.i_ch(r_green),    .i_brightness(bus.brightness), .o_ch(w_green_s));
  pixel_scale u_scale_b (.i_ch(bus.s_data), .i_brightness(bus.brightness), .o_ch(w_blue_s));
`else
  assign w_red_s   = r_red;
  assign w_green_s = r_green;
  assign w_blue_s  = bus.s_data;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_COLLECT: if (w_last_byte) w_next = ST_SETUP;
      ST_SETUP:   w_next = ST_STROBE;
      ST_STROBE:  w_next = ST_HOLD;
      ST_HOLD:    w_next = ST_COLLECT;
      default:    w_next = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs are registered from the next state so the driver sees glitch-free
  // levels: colour/address load on entry to SETUP (blue comes straight from
  // the bus on that edge), pix_wr is high exactly while in STROBE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt   <= '0;
      r_red        <= '0;
      r_green      <= '0;
      r_addr_cnt   <= '0;
      r_pix_color  <= '0;
      r_pix_addr   <= '0;
      r_wr         <= 1'b0;
      r_frame_done <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_ready      <= (w_next == ST_COLLECT);
      r_wr         <= (w_next == ST_STROBE);
      r_frame_done <= (r_state == ST_HOLD) && (r_addr_cnt == LAST_ADDR);

      if (w_accept) begin
        if (bus.s_sof) begin
          // Restart the frame; any partial pixel is dropped.
          r_red      <= bus.s_data;
          r_byte_cnt <= 2'd1;
          r_addr_cnt <= '0;
        end else if (r_byte_cnt == 2'd0) begin
          r_red      <= bus.s_data;
          r_byte_cnt <= 2'd1;
        end else if (r_byte_cnt == 2'd1) begin
          r_green    <= bus.s_data;
          r_byte_cnt <= 2'd2;
        end else begin
          r_byte_cnt <= 2'd0;
        end
      end else if (r_state == ST_HOLD) begin
        r_addr_cnt <= (r_addr_cnt == LAST_ADDR) ? '0 : r_addr_cnt + 1'b1;
      end

      if (w_last_byte) begin
        r_pix_color <= pack_grb(w_red_s, w_green_s, w_blue_s);
        r_pix_addr  <= r_addr_cnt;
      end
    end
  end

  assign bus.s_ready     = r_ready;
  assign bus.pix_color   = r_pix_color;
  assign bus.pix_address = r_pix_addr;
  assign bus.pix_wr      = r_wr;
  assign bus.frame_done  = r_frame_done;
  assign bus.busy        = (r_state != ST_COLLECT);
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_pixel_stream_loader.sv
// tb_pixel_stream_loader
//   Directed bench for pixel_stream_loader (NUM_LEDS=16). A negedge monitor
//   records every driver write as {address, colour} plus the cycle it was
//   seen; each test task drives bytes and compares against hand-computed
//   expectations. Build with PIXEL_BRIGHTNESS_EN to add the scaling test.
module tb_pixel_stream_loader;
  import pixel_stream_loader_pkg::*;

  localparam int NUM_LEDS = 16;
  localparam int ADDR_W   = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pixel_stream_loader_if #(.ADDR_W(ADDR_W)) bus ();
  state_t dbg_state;

  pixel_stream_loader #(.NUM_LEDS(NUM_LEDS), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [39:0] exp_q[$];
  logic [39:0] got_q[$];
  int          got_cyc_q[$];
  int          fd_cnt = 0;
  int          fd_cyc = 0;
  int          xfer_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pix_wr) begin
        got_q.push_back({bus.pix_address, bus.pix_color});
        got_cyc_q.push_back(cyc);
      end
      if (bus.frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Tasks start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] d, input logic sof);
    int t;
    t = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_sof   = sof;
    while (!bus.s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (bus.s_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_byte_ready got=%b want=1 (byte %h)", bus.s_ready, d);
    end
    @(negedge clk);
    xfer_cyc = cyc;
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
    fd_cnt = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.s_ready, bus.pix_wr, bus.frame_done, bus.busy} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000", {bus.s_ready, bus.pix_wr, bus.frame_done, bus.busy});
    end
    total++;
    if ({bus.pix_address, bus.pix_color} !== 40'd0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0", {bus.pix_address, bus.pix_color});
    end
    total++;
    if (dbg_state !== ST_COLLECT) begin
      bad++;
      $display("FAIL reset_state got=%0d want=%0d", dbg_state, ST_COLLECT);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (bus.s_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_before_clk got=%b want=0", bus.s_ready);
    end
    @(negedge clk);
    total++;
    if (bus.s_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_after_clk got=%b want=1", bus.s_ready);
    end
  endtask

  task automatic test_first_pixel();
    int n;
    logic [3:0] e_ready, e_wr, e_busy;
    e_ready = 4'b1000;  // index k = cycles after the 3rd byte edge
    e_wr    = 4'b0010;
    e_busy  = 4'b0111;
    clear_sb();
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h80, 1'b0);
    n = xfer_cyc;
    bus.s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({bus.s_ready, bus.pix_wr, bus.busy} !== {e_ready[k], e_wr[k], e_busy[k]}) begin
        bad++;
        $display("FAIL first_timing k=%0d got ready/wr/busy=%b want=%b", k,
                 {bus.s_ready, bus.pix_wr, bus.busy}, {e_ready[k], e_wr[k], e_busy[k]});
      end
      total++;
      if ({bus.pix_address, bus.pix_color} !== {16'd0, 24'h00FF80}) begin
        bad++;
        $display("FAIL first_data k=%0d got=%h want=%h", k,
                 {bus.pix_address, bus.pix_color}, {16'd0, 24'h00FF80});
      end
      @(negedge clk);
    end
    idle(4);
    total++;
    if (got_q.size() != 1) begin
      bad++;
      $display("FAIL first_write_count got=%0d want=1", got_q.size());
    end else begin
      total++;
      if (got_cyc_q[0] != n + 1) begin
        bad++;
        $display("FAIL first_wr_latency got=%0d want=%0d", got_cyc_q[0] - n, 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  r, g, b;
    logic [15:0] a;
    clear_sb();
    for (int p = 0; p < 17; p++) begin
      r = 8'(p);
      g = 8'h10 + 8'(p);
      b = 8'hA0 + 8'(p);
      a = 16'(p % NUM_LEDS);
      exp_q.push_back({a, g, r, b});
      send_byte(r, (p == 0));
      send_byte(g, 1'b0);
      send_byte(b, 1'b0);
    end
    idle(8);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL b2b_write_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_write[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
      if (i > 0) begin
        total++;
        if (got_cyc_q[i] - got_cyc_q[i-1] != 6) begin
          bad++;
          $display("FAIL b2b_spacing[%0d] got=%0d want=6", i, got_cyc_q[i] - got_cyc_q[i-1]);
        end
      end
    end
    total++;
    if (fd_cnt != 1) begin
      bad++;
      $display("FAIL b2b_frame_done_count got=%0d want=1", fd_cnt);
    end
    if (got_cyc_q.size() > 15) begin
      total++;
      if (fd_cyc != got_cyc_q[15] + 2) begin
        bad++;
        $display("FAIL b2b_frame_done_time got=%0d want=%0d", fd_cyc, got_cyc_q[15] + 2);
      end
    end
  endtask

  task automatic test_sof_restart();
    clear_sb();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    idle(8);
    exp_q.push_back({16'd0, 24'h221133});
    total++;
    if (got_q.size() != 1) begin
      bad++;
      $display("FAIL sof_write_count got=%0d want=1", got_q.size());
    end else begin
      total++;
      if (got_q[0] !== exp_q[0]) begin
        bad++;
        $display("FAIL sof_write got=%h want=%h", got_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    clear_sb();
    exp_q.push_back({16'd1, 24'h020103});
    exp_q.push_back({16'd0, 24'h887799});
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    bus.s_valid = 1'b0;
    @(posedge clk);
    #2;
    total++;
    if ({bus.pix_wr, dbg_state} !== {1'b1, ST_STROBE}) begin
      bad++;
      $display("FAIL midrst_pre got wr/state=%b/%0d want=1/%0d", bus.pix_wr, dbg_state, ST_STROBE);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.pix_wr !== 1'b0) begin
      bad++;
      $display("FAIL midrst_wr got=%b want=0", bus.pix_wr);
    end
    total++;
    if ({bus.s_ready, bus.frame_done, bus.busy, bus.pix_address, bus.pix_color} !== 43'd0) begin
      bad++;
      $display("FAIL midrst_outputs got=%h want=0",
               {bus.s_ready, bus.frame_done, bus.busy, bus.pix_address, bus.pix_color});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    send_byte(8'h99, 1'b0);
    idle(8);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL midrst_write_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL midrst_write[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_valid_toggle();
    logic [7:0] bytes [6];
    bytes = '{8'hC1, 8'hC2, 8'hC3, 8'hD1, 8'hD2, 8'hD3};
    clear_sb();
    exp_q.push_back({16'd0, 24'hC2C1C3});
    exp_q.push_back({16'd1, 24'hD2D1D3});
    for (int i = 0; i < 6; i++) begin
      send_byte(bytes[i], (i == 0));
      bus.s_valid = 1'b0;
      bus.s_sof   = 1'b0;
      @(negedge clk);
    end
    idle(8);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL toggle_write_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL toggle_write[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

`ifdef PIXEL_BRIGHTNESS_EN
  task automatic test_brightness();
    logic [7:0]  gain [2];
    logic [39:0] want [2];
    gain = '{8'h7F, 8'hFF};
    want = '{{16'd0, 24'h407F00}, {16'd0, 24'h80FF00}};
    for (int i = 0; i < 2; i++) begin
      clear_sb();
      bus.brightness = gain[i];
      send_byte(8'hFF, 1'b1);
      send_byte(8'h80, 1'b0);
      send_byte(8'h00, 1'b0);
      idle(8);
      total++;
      if (got_q.size() != 1) begin
        bad++;
        $display("FAIL bright_write_count[%0d] got=%0d want=1", i, got_q.size());
      end else begin
        total++;
        if (got_q[0] !== want[i]) begin
          bad++;
          $display("FAIL bright_write[%0d] got=%h want=%h", i, got_q[0], want[i]);
        end
      end
    end
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_sof   = 1'b0;
`ifdef PIXEL_BRIGHTNESS_EN
    bus.brightness = 8'hFF;
`endif
    test_reset();
    test_first_pixel();
    test_back_to_back();
    test_sof_restart();
    test_reset_mid_write();
    test_valid_toggle();
`ifdef PIXEL_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
